uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver: 8N1, LSB first, idle-high line.
- Recovers bytes from the asynchronous rx pin and presents each one as rx_data with a single-cycle rx_done strobe.
- Sits directly upstream of the keyboard FIFO, whose write input is rx_done and whose data input is rx_data.
- Uses oversampled mid-bit sampling with start-bit glitch rejection and stop-bit framing check.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and >= 8.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line, asynchronous to clk.
- rx_data  output  8  last correctly framed byte; holds until the next good frame.
- rx_done  output  1  one-cycle pulse; rx_data is valid in the same cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0.
- Reset values (internal): synchronizer flops=1, state=IDLE, all counters=0.
- Synchronizer: 2-flop on rx, followed by a registered copy rx_prev used for edge detection. Input-to-rx_s latency is 2 cycles.
- Tick generator:
  - DIV = round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE)); the default gives 54.
  - Counts 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - Held at 0 in IDLE; restarts at 0 on start detection, so sampling phase is locked to the start edge.
- Counters: tick_cnt ranges 0..OVERSAMPLE-1; bit_cnt is 3 bits.
- IDLE:
  - Arms only on a falling edge (rx_prev=1, rx_s=0).
  - A line held low (break) never re-triggers.
  - On the edge: go to START, clear tick_cnt.
- START: at tick_cnt = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, clear tick_cnt and bit_cnt.
  - rx_s=1: glitch; return to IDLE with no output.
- DATA:
  - Each time tick_cnt reaches OVERSAMPLE-1, sample rx_s into shift[7] and shift right.
  - After the 8th sample (bit_cnt=7), go to STOP.
- STOP: at tick_cnt = OVERSAMPLE-1, sample rx_s.
  - rx_s=1: on the next clk edge, rx_data<=shift and rx_done=1 for exactly one cycle.
  - rx_s=0: frame_err=1 for one cycle; rx_data unchanged.
  - Either way, go to IDLE.
- Byte latency: rx_done rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times plus 3 clk after the start edge.
- rx_done and frame_err are mutually exclusive and never asserted on consecutive cycles.
- Back-to-back frames: IDLE is reached at mid stop bit, so a start edge in the following half bit is caught. There are no dead cycles.
- Reset mid-frame: immediately return to IDLE; the partial byte is discarded; no rx_done or frame_err pulse.
- Downstream has no backpressure. A dropped byte when the FIFO is full is the FIFO's concern; uart_rx never stalls.

Decomposition:
- Package uart_pkg contains:
  - rx_state_t enum: IDLE, START, DATA, STOP.
  - Function calc_div(clk_freq, baud, os) returning the rounded divisor.
  - Constants DATA_BITS=8 and the line idle level 1'b1.
- One sub-module, uart_baud_tick. Parameter: DIV. Inputs: clk, reset, clear. Output: tick.
- The future uart_tx reuses uart_baud_tick and uart_pkg.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving DIV=10 and 160 clk per bit.
- Single frame 8'h41, stop=1 -> exactly one rx_done pulse; rx_data=8'h41; frame_err never high; rx_busy low after the pulse.
- Back-to-back 8'h55 then 8'hAA with no idle gap -> two rx_done pulses about 1600 clk apart; rx_data=8'h55 then 8'hAA.
- rx low glitch of 40 clk (shorter than half a bit) -> no rx_done or frame_err; rx_busy high for about 80 clk then low; a following 8'h0D frame is received correctly.
- Frame 8'h7E with stop bit 0 after a good 8'h41 -> one frame_err pulse; no rx_done; rx_data stays 8'h41.
- Line then held low for 2000 clk before returning high (break) -> no further pulses of either output.
- Reset pulsed low during data bit 4 of 8'h33 -> outputs at reset values within 1 cycle, with no pulses; a subsequent 8'h33 frame is received correctly.
- Transmitter bit period 152 clk (-5%) and 168 clk (+5%) sending 8'hC3 -> rx_data=8'hC3 in both cases; no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// oversampling divisor helper used by uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    // Divisor from clk to one oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int denom;
        denom = baud * os;
        return (clk_freq + denom / 2) / denom;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick for one clk at
// DIV-1. While clear is high the count is held at 0 and no tick is emitted.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick = !clear && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, start-glitch rejection
// and stop-bit framing check. rx_done/frame_err are single-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int              DIV       = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int              TCW       = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0]  TICK_MID  = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0]  TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    logic rx_meta_q, rx_s_q, rx_prev_q;

    rx_state_t              state_q,     state_d;
    logic [TCW-1:0]         tick_cnt_q,  tick_cnt_d;
    logic [2:0]             bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [7:0]             rx_data_q,   rx_data_d;
    logic                   rx_done_q,   rx_done_d;
    logic                   frame_err_q, frame_err_d;

    logic tick;
    logic start_edge;

    // NOTE: the synchronizer resets to the idle level so releasing reset
    // cannot fabricate a falling edge on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= LINE_IDLE;
            rx_s_q    <= LINE_IDLE;
            rx_prev_q <= LINE_IDLE;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_edge = (rx_prev_q == LINE_IDLE) && (rx_s_q != LINE_IDLE);

    // Held in IDLE so the tick phase is locked to the detected start edge.
    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (start_edge) begin
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (rx_s_q != LINE_IDLE) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s_q == LINE_IDLE) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
